// File: rtl/core_dequant_pkg.sv
// Shared constants for the integer-lane dequantizer: default geometry,
// configuration field widths, shift ceiling and output saturation limits.
package core_dequant_pkg;

  localparam int DEQUANT_IDATA_BIT_DEF = 8;
  localparam int DEQUANT_ODATA_BIT_DEF = 16;
  localparam int DEQUANT_LANES_DEF     = 4;

  localparam int DEQUANT_SCALE_BIT = 16;
  localparam int DEQUANT_SHIFT_BIT = 5;

  localparam int DEQUANT_MAX_SHIFT = 24;
  localparam int DEQUANT_SAT_MAX   = 32767;
  localparam int DEQUANT_SAT_MIN   = -32768;

endpackage

// File: rtl/core_dequant_unpack.sv
// Word-to-lane unpacker: one holding register plus a lane counter, issuing
// lane 0 first and accepting the next word while the last lane leaves.
module core_dequant_unpack
  import core_dequant_pkg::*;
#(
  parameter int IW    = DEQUANT_IDATA_BIT_DEF,
  parameter int LANES = DEQUANT_LANES_DEF
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [LANES*IW-1:0] idata_i,
  input  logic               idata_valid_i,
  input  logic               idata_last_i,
  output logic               idata_ready_o,
  output logic               lane_valid_o,
  output logic [IW-1:0]      lane_data_o,
  output logic               lane_last_o
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                hold_valid_q, hold_valid_d;
  logic                hold_last_q;
  logic [LANES*IW-1:0] hold_data_q;
  logic [CW-1:0]       lane_cnt_q, lane_cnt_d;
  logic                last_lane;
  logic                accept;

  assign last_lane     = (lane_cnt_q == CW'(LANES - 1));
  // Refilling while the final lane advances keeps back-to-back words gapless.
  assign idata_ready_o = !rst_i && (!hold_valid_q || (en_i && last_lane));
  assign accept        = idata_valid_i && idata_ready_o;

  assign lane_valid_o = hold_valid_q;
  assign lane_data_o  = hold_data_q[lane_cnt_q*IW +: IW];
  assign lane_last_o  = hold_last_q && last_lane;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hold_valid_d = hold_valid_q;
    lane_cnt_d   = lane_cnt_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      lane_cnt_d   = '0;
    end else if (en_i && hold_valid_q) begin
      if (last_lane) begin
        hold_valid_d = 1'b0;
        lane_cnt_d   = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      lane_cnt_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      lane_cnt_q   <= lane_cnt_d;
      if (accept) hold_last_q <= idata_last_i;
    end
  end

  // NOTE: payload registers are not reset; the valid bit guards their use.
  always_ff @(posedge clk) begin
    if (accept) hold_data_q <= idata_i;
  end

endmodule

// File: rtl/core_dequant.sv
// Streaming dequantizer: unpacks signed integer lanes and computes
// sat(round(((x - zero) * scale) >>> shift)) through a 3-stage pipeline.
module core_dequant
  import core_dequant_pkg::*;
#(
  parameter int DEQUANT_IDATA_BIT = DEQUANT_IDATA_BIT_DEF,
  parameter int DEQUANT_ODATA_BIT = DEQUANT_ODATA_BIT_DEF,
  parameter int DEQUANT_LANES     = DEQUANT_LANES_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [DEQUANT_SCALE_BIT-1:0]               cfg_dequant_scale,
  input  logic [DEQUANT_IDATA_BIT-1:0]               cfg_dequant_zero,
  input  logic [DEQUANT_SHIFT_BIT-1:0]               cfg_dequant_shift,
  input  logic [DEQUANT_LANES*DEQUANT_IDATA_BIT-1:0] idata,
  input  logic                                       idata_valid,
  output logic                                       idata_ready,
  input  logic                                       idata_last,
  output logic [DEQUANT_ODATA_BIT-1:0]               odata,
  output logic                                       odata_valid,
  input  logic                                       odata_ready,
  output logic                                       odata_last,
  output logic                                       busy
);

  localparam int IW = DEQUANT_IDATA_BIT;
  localparam int DW = IW + 1;                  // x - zero
  localparam int PW = DW + DEQUANT_SCALE_BIT;  // full product
  localparam int RW = PW + 1;                  // headroom for the rounding add

  localparam logic signed [RW-1:0] SAT_HI = RW'(DEQUANT_SAT_MAX);
  localparam logic signed [RW-1:0] SAT_LO = RW'(DEQUANT_SAT_MIN);
  localparam logic [DEQUANT_SHIFT_BIT-1:0] SHIFT_CAP = DEQUANT_SHIFT_BIT'(DEQUANT_MAX_SHIFT);

  logic          en;
  logic          lane_valid, lane_last;
  logic [IW-1:0] lane_data;

  logic                 s1_valid_q, s1_last_q;
  logic signed [PW-1:0] s1_prod_q;
  logic                 s2_valid_q, s2_last_q;
  logic signed [RW-1:0] s2_val_q;
  logic                 odata_valid_q, odata_last_q;
  logic [DEQUANT_ODATA_BIT-1:0] odata_q;

  logic signed [DW-1:0]         diff;
  logic signed [PW-1:0]         prod_d;
  logic [DEQUANT_SHIFT_BIT-1:0] shamt;
  logic signed [RW-1:0]         prod_ext, rnd, rsum, shifted_d, clamped;
  logic [DEQUANT_ODATA_BIT-1:0] odata_d;

  assign en = !odata_valid_q || odata_ready;

  core_dequant_unpack #(
    .IW    (IW),
    .LANES (DEQUANT_LANES)
  ) u_unpack (
    .clk           (clk),
    .rst_i         (rst),
    .en_i          (en),
    .idata_i       (idata),
    .idata_valid_i (idata_valid),
    .idata_last_i  (idata_last),
    .idata_ready_o (idata_ready),
    .lane_valid_o  (lane_valid),
    .lane_data_o   (lane_data),
    .lane_last_o   (lane_last)
  );

  assign diff   = $signed({lane_data[IW-1], lane_data})
                - $signed({cfg_dequant_zero[IW-1], cfg_dequant_zero});
  assign prod_d = $signed({{(PW-DW){diff[DW-1]}}, diff})
                * $signed({{(PW-DEQUANT_SCALE_BIT){cfg_dequant_scale[DEQUANT_SCALE_BIT-1]}},
                           cfg_dequant_scale});

  assign shamt     = (cfg_dequant_shift > SHIFT_CAP) ? SHIFT_CAP : cfg_dequant_shift;
  assign prod_ext  = {s1_prod_q[PW-1], s1_prod_q};
  assign rnd       = (shamt == '0) ? '0 : (RW'(1) << (shamt - 5'd1));
  assign rsum      = prod_ext + rnd;
  assign shifted_d = rsum >>> shamt;

  always_comb begin
    clamped = s2_val_q;
    if (s2_val_q > SAT_HI)      clamped = SAT_HI;
    else if (s2_val_q < SAT_LO) clamped = SAT_LO;
  end
  assign odata_d = clamped[DEQUANT_ODATA_BIT-1:0];

  // Control: all stages step together on en; bubbles travel as bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_last_q     <= 1'b0;
      odata_valid_q <= 1'b0;
      odata_last_q  <= 1'b0;
      odata_q       <= '0;
    end else if (en) begin
      s1_valid_q    <= lane_valid;
      s1_last_q     <= lane_valid && lane_last;
      s2_valid_q    <= s1_valid_q;
      s2_last_q     <= s1_last_q;
      odata_valid_q <= s2_valid_q;
      odata_last_q  <= s2_last_q;
      if (s2_valid_q) odata_q <= odata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (lane_valid) s1_prod_q <= prod_d;
      if (s1_valid_q) s2_val_q  <= shifted_d;
    end
  end

  assign odata       = odata_q;
  assign odata_valid = odata_valid_q;
  assign odata_last  = odata_last_q;
  assign busy        = lane_valid || s1_valid_q || s2_valid_q || odata_valid_q;

endmodule

// File: tb/tb_core_dequant.sv
// Directed self-checking bench for core_dequant: arithmetic corners,
// latency, backpressure stability and mid-stream reset.
module tb_core_dequant;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_dequant_scale;
  logic [7:0]  cfg_dequant_zero;
  logic [4:0]  cfg_dequant_shift;
  logic [31:0] idata;
  logic        idata_valid, idata_ready, idata_last;
  logic [15:0] odata;
  logic        odata_valid, odata_ready, odata_last;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_dequant dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_dequant_scale (cfg_dequant_scale),
    .cfg_dequant_zero  (cfg_dequant_zero),
    .cfg_dequant_shift (cfg_dequant_shift),
    .idata             (idata),
    .idata_valid       (idata_valid),
    .idata_ready       (idata_ready),
    .idata_last        (idata_last),
    .odata             (odata),
    .odata_valid       (odata_valid),
    .odata_ready       (odata_ready),
    .odata_last        (odata_last),
    .busy              (busy)
  );

  // Collect every completed output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && odata_valid && odata_ready) begin
      got_data.push_back(odata);
      got_last.push_back(odata_last);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic set_cfg(input logic [15:0] scale, input logic [7:0] zero, input logic [4:0] shift);
    cfg_dequant_scale = scale;
    cfg_dequant_zero  = zero;
    cfg_dequant_shift = shift;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, output int acc_cyc);
    idata       = w;
    idata_last  = last;
    idata_valid = 1'b1;
    acc_cyc     = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (idata_ready) begin
        tick();
        acc_cyc     = cyc;
        idata_valid = 1'b0;
        idata_last  = 1'b0;
        return;
      end
    end
    idata_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_outputs(input int n);
    for (int i = 0; i < 300 && got_data.size() < n; i++) tick();
    if (got_data.size() < n) check("out_timeout", got_data.size(), n);
  endtask

  // exp packs the four expected lanes, lane 0 in the low 16 bits.
  task automatic run_word(input string tag, input logic [31:0] w, input logic [63:0] exp);
    int acc;
    clear_q();
    send_word(w, 1'b0, acc);
    wait_outputs(4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_lane%0d", tag, i), got_data[i], exp[i*16 +: 16]);
        check($sformatf("%s_last%0d", tag, i), got_last[i], 1'b0);
      end
    end
    tick();
    tick();
    check($sformatf("%s_idle", tag), busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    logic [63:0] exp;

    rst         = 1'b1;
    idata       = '0;
    idata_valid = 1'b0;
    idata_last  = 1'b0;
    odata_ready = 1'b1;
    set_cfg(16'h0, 8'h0, 5'd0);

    // Reset behaviour.
    tick();
    tick();
    @(negedge clk);
    check("rst_ready_low", idata_ready, 1'b0);
    check("rst_ovalid_low", odata_valid, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", idata_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_odata", odata, 16'h0);
    check("post_rst_ovalid", odata_valid, 1'b0);
    tick();

    // Basic path with latency.
    set_cfg(16'h0100, 8'h00, 5'd8);
    clear_q();
    send_word(32'h01807FFF, 1'b0, acc);
    wait_outputs(4);
    exp = {16'h0001, 16'hFF80, 16'h007F, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("basic_lane%0d", i), got_data[i], exp[i*16 +: 16]);
        check($sformatf("basic_cyc%0d", i), got_cyc[i], acc + 3 + i);
      end
    end
    tick();
    tick();
    check("basic_idle", busy, 1'b0);

    // Saturation.
    set_cfg(16'h7FFF, 8'h00, 5'd0);
    run_word("sat", 32'h0000807F, {16'h0000, 16'h0000, 16'h8000, 16'h7FFF});

    // Round half up.
    set_cfg(16'h0003, 8'h00, 5'd1);
    run_word("round", 32'h0000FF01, {16'h0000, 16'h0000, 16'hFFFF, 16'h0002});

    // Shift beyond the cap behaves as 24.
    set_cfg(16'h7FFF, 8'h00, 5'd31);
    run_word("shcap", 32'h0080FF80, 64'h0);

    // Zero point.
    set_cfg(16'h0001, 8'h80, 5'd0);
    run_word("zero", 32'h0000807F, {16'h0080, 16'h0080, 16'h0000, 16'h00FF});

    // Backpressure over a 3-word vector.
    set_cfg(16'h0001, 8'h00, 5'd0);
    clear_q();
    fork
      begin
        int a;
        send_word(32'h04030201, 1'b0, a);
        send_word(32'h08070605, 1'b0, a);
        send_word(32'h0C0B0A09, 1'b1, a);
      end
      begin
        for (int i = 0; i < 300 && got_data.size() < 3; i++) tick();
        odata_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n = got_data.size();
          check($sformatf("stall%0d_valid", i), odata_valid, 1'b1);
          check($sformatf("stall%0d_data", i), odata, n + 1);
          check($sformatf("stall%0d_last", i), odata_last, n == 11);
          check($sformatf("stall%0d_iready", i), idata_ready, 1'b0);
        end
        tick();
        odata_ready = 1'b1;
      end
    join
    wait_outputs(12);
    check("bp_count", got_data.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("bp_lane%0d", i), got_data[i], i + 1);
        check($sformatf("bp_last%0d", i), got_last[i], i == 11);
      end
    end
    tick();
    tick();
    check("bp_idle", busy, 1'b0);

    // Reset in the middle of a word.
    clear_q();
    send_word(32'h11223344, 1'b0, acc);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", idata_ready, 1'b0);
    tick();
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    check("mid_ovalid", odata_valid, 1'b0);
    check("mid_odata", odata, 16'h0);
    check("mid_busy_clr", busy, 1'b0);
    check("mid_ready", idata_ready, 1'b1);
    repeat (10) tick();
    check("mid_no_stale", got_data.size(), 0);
    run_word("after_rst", 32'h05FB7F80, {16'h0005, 16'hFFFB, 16'h007F, 16'hFF80});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_dequant.md
CORE_DEQUANT -- requirements
Module: core_dequant

Interface
REQ-001 Parameter DEQUANT_IDATA_BIT, default 8, SHALL be the signed integer lane width.
REQ-002 Parameter DEQUANT_ODATA_BIT, default 16, SHALL be the signed dequantized output width.
REQ-003 Parameter DEQUANT_LANES, default 4, SHALL be the number of lanes packed per input word; lane 0 occupies the LSBs.
REQ-004 Port clk, input, 1: the single clock; every register SHALL sample on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port cfg_dequant_scale, input, 16: signed multiplier.
REQ-007 Port cfg_dequant_zero, input, DEQUANT_IDATA_BIT: signed zero point.
REQ-008 Port cfg_dequant_shift, input, 5: right-shift amount.
REQ-009 Port idata, input, DEQUANT_LANES*DEQUANT_IDATA_BIT: packed input word.
REQ-010 Port idata_valid / idata_ready, input / output, 1 each: input handshake; a word transfers on an edge where both are 1.
REQ-011 Port idata_last, input, 1: end-of-vector flag qualified by the input handshake.
REQ-012 Port odata, output, DEQUANT_ODATA_BIT: one dequantized lane.
REQ-013 Port odata_valid / odata_ready, output / input, 1 each: output handshake.
REQ-014 Port odata_last, output, 1: high only on the final lane of a word accepted with idata_last=1.
REQ-015 Port busy, output, 1: high while any word or lane is held anywhere in the block.

Function
REQ-016 Per lane, the block SHALL compute d = (x - zero) * scale, where x - zero is 9-bit signed and d is 25-bit signed, with no loss of precision.
REQ-017 Shift: s = min(cfg_dequant_shift, 24).
- s = 0: r = d.
- s > 0: r = (d + 2^(s-1)) >>> s, arithmetic shift, round half up, evaluated at 26 bits.
REQ-018 Saturation: r SHALL be clamped to [-32768, 32767] before it drives odata.
REQ-019 Unpacker:
- One holding register plus a lane counter (0..DEQUANT_LANES-1).
- Issues lane 0 first, one lane per advancing cycle.
- The counter wraps to 0 after the last lane, and the holding register then empties.
REQ-020 idata_ready SHALL be 1 when the holding register is empty, or when it is issuing its last lane in an advancing cycle, so back-to-back words stream with no gap.
REQ-021 Pipeline: three registered stages (multiply, shift/round, saturate/output).
- All stages and the unpacker advance together when en = !odata_valid || odata_ready.
- When en = 0, every stage holds its contents.
REQ-022 Latency without stall: lane i of a word accepted on edge k SHALL appear on odata with odata_valid=1 after edge k+3+i.
REQ-023 When odata_valid=1 and odata_ready=0, odata, odata_valid and odata_last SHALL stay stable until the transfer completes.
REQ-024 No lane SHALL be dropped, duplicated or reordered under any valid/ready pattern.
REQ-025 Configuration SHALL be sampled at the multiply stage (scale, zero) and at the shift stage (shift); changing it while busy=1 is unsupported.
REQ-026 Bubbles (a stage holding no valid lane) SHALL propagate as bubbles; the pipeline does not collapse them.

Reset
REQ-027 On a rising edge with rst=1, the block SHALL clear:
- all stage valid bits, the holding-register valid bit and the lane counter;
- odata = 0, odata_valid = 0, odata_last = 0.
rst SHALL take priority over every handshake.
REQ-028 idata_ready SHALL be 0 while rst=1; the cycle after rst deasserts, idata_ready = 1 and busy = 0.
REQ-029 A reset mid-stream SHALL discard all in-flight lanes; no partial word is emitted afterwards.

Structure
REQ-030 A shared package SHALL define:
- the default widths and lane count;
- the maximum shift (24);
- the saturation limits (DEQUANT_SAT_MAX = 32767, DEQUANT_SAT_MIN = -32768).
REQ-031 The unpacker (holding register, lane counter, last-lane detect, idata_ready) SHALL be a sub-module, core_dequant_unpack; the arithmetic pipeline stays in core_dequant.

Verification
REQ-032 Basic path: zero=0, scale=0x0100, shift=8, idata=0x01807FFF with odata_ready=1 -> odata 0xFFFF, 0x007F, 0xFF80, 0x0001 on four consecutive cycles, the first 3 cycles after acceptance.
REQ-033 Saturation: scale=0x7FFF, shift=0, zero=0, lanes 0x7F and 0x80 -> 0x7FFF and 0x8000.
REQ-034 Rounding: scale=3, shift=1, zero=0, lanes 0x01 and 0xFF -> 0x0002 and 0xFFFF; shift=31 treated as 24.
REQ-035 Zero point: zero=0x80, scale=1, shift=0, lanes 0x7F and 0x80 -> 0x00FF and 0x0000.
REQ-036 Backpressure: stream 3 words with idata_last on the third, hold odata_ready=0 for 5 cycles mid-stream -> odata stable while stalled, all 12 lanes in order, odata_last only on lane 11, idata_ready=0 while full.
REQ-037 Reset mid-stream: assert rst for 1 cycle with busy=1 -> next cycle odata_valid=0, odata=0, busy=0, idata_ready=1, and no stale lane emitted later.
